// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, the data load/store port and the unified memory
// port of the processor memory arbiter.
//   slave  : arbiter view. Requests, store data and mem_rdata come in.
//            Ready pulses, read data, memory strobes, busy and gnt_d go out.
//   master : view of the surrounding system (processor + memory). It is the
//            mirror image of slave.
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // instruction-fetch port (read-only)
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_ready;
    logic [DATA_W-1:0]     if_rdata;
    // data load/store port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wstrb;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_rdata;
    // unified memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_rdata;
    // status
    logic                  busy;
    logic                  gnt_d;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_ready, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata,
        output busy, gnt_d
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_ready, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata,
        input  busy, gnt_d
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port, fixed-latency memory between the instruction-fetch
// port and the data load/store port. Accesses are serialised by a four-state
// FSM (IDLE -> ISSUE -> WAIT -> RESP). Each completed transaction returns
// exactly one ready pulse. Ties are broken round-robin.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; aborts any transaction in flight
//   bus   : mem_port_arbiter_if.slave (fetch, data and memory ports,
//           busy, gnt_d)
// Every output is a register, so no input reaches an output combinationally.
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LAT - 1);

    state_t                r_state;
    logic [3:0]            r_cnt;
    logic                  r_we;        // granted transaction is a store
    logic                  r_last_d;    // last served port: 1 = data
    logic                  r_gnt_d;
    logic                  r_busy;
    logic                  r_if_ready;
    logic                  r_d_ready;
    logic [DATA_W-1:0]     r_if_rdata;
    logic [DATA_W-1:0]     r_d_rdata;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_W-1:0]     r_mem_addr;
    logic [DATA_W-1:0]     r_mem_wdata;
    logic [DATA_W/8-1:0]   r_mem_wstrb;

    logic                  w_any_req;
    logic                  w_pick_d;

    // Data wins when it is the only requester, or when both request and
    // fetch was served last.
    assign w_any_req = bus.if_req | bus.d_req;
    assign w_pick_d  = bus.d_req & (~bus.if_req | ~r_last_d);

    // Arbitration FSM with all outputs registered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_we        <= 1'b0;
            r_last_d    <= 1'b0;
            r_gnt_d     <= 1'b0;
            r_busy      <= 1'b0;
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
        end else begin
            // Pulses and memory strobes are zero unless a state drives them.
            r_if_ready  <= 1'b0;
            r_d_ready   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        // The memory-port registers hold the latched request
                        // and are visible during ISSUE.
                        r_gnt_d    <= w_pick_d;
                        r_we       <= w_pick_d & bus.d_we;
                        r_busy     <= 1'b1;
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= w_pick_d & bus.d_we;
                        r_mem_addr <= w_pick_d ? bus.d_addr : bus.if_addr;
                        if (w_pick_d) begin
                            r_mem_wdata <= bus.d_wdata;
                            r_mem_wstrb <= bus.d_wstrb;
                        end else begin
                            r_mem_wdata <= '0;
                            r_mem_wstrb <= '0;
                        end
                        r_state    <= ST_ISSUE;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= LP_CNT_INIT;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        // mem_rdata is valid now; stores leave rdata untouched.
                        if (!r_we) begin
                            if (r_gnt_d) begin
                                r_d_rdata  <= bus.mem_rdata;
                            end else begin
                                r_if_rdata <= bus.mem_rdata;
                            end
                        end
                        r_d_ready  <= r_gnt_d;
                        r_if_ready <= ~r_gnt_d;
                        r_state    <= ST_RESP;
                    end else begin
                        r_cnt      <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Requests are not sampled here, so a requester that
                    // drops req after its ready pulse is not served twice.
                    r_last_d <= r_gnt_d;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.if_ready  = r_if_ready;
    assign bus.if_rdata  = r_if_rdata;
    assign bus.d_ready   = r_d_ready;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.mem_en    = r_mem_en;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_wstrb = r_mem_wstrb;
    assign bus.busy      = r_busy;
    assign bus.gnt_d     = r_gnt_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Two instances are used, one with
// MEM_LAT=2 and one with MEM_LAT=1. Each instance has a small read-only
// memory model whose data is valid for exactly one cycle, MEM_LAT cycles
// after the mem_en cycle. Cycle numbers in the comments count from the
// cycle in which the request is first visible (cycle 0).
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam logic [31:0] GARB = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc2 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) ifc1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc2)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc1)
    );

    // Memory contents as a function of the address
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    logic [31:0] r_pipe2 [2];
    logic [31:0] r_pipe1;

    // Memory models: read data is valid only in cycle mem_en + MEM_LAT
    always @(posedge clk) begin
        r_pipe2[0] <= (ifc2.mem_en && !ifc2.mem_we) ? memword(ifc2.mem_addr) : GARB;
        r_pipe2[1] <= r_pipe2[0];
        r_pipe1    <= (ifc1.mem_en && !ifc1.mem_we) ? memword(ifc1.mem_addr) : GARB;
    end
    assign ifc2.mem_rdata = r_pipe2[1];
    assign ifc1.mem_rdata = r_pipe1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ifc2.if_req = 1'b0; ifc2.if_addr = 32'h0; ifc2.d_req = 1'b0; ifc2.d_we = 1'b0;
        ifc2.d_addr = 32'h0; ifc2.d_wdata = 32'h0; ifc2.d_wstrb = 4'h0;
        ifc1.if_req = 1'b0; ifc1.if_addr = 32'h0; ifc1.d_req = 1'b0; ifc1.d_we = 1'b0;
        ifc1.d_addr = 32'h0; ifc1.d_wdata = 32'h0; ifc1.d_wstrb = 4'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // reset state
        chk("rst_mem_en", ifc2.mem_en, 1'b0);
        chk("rst_busy", ifc2.busy, 1'b0);
        chk("rst_gnt_d", ifc2.gnt_d, 1'b0);
        chk("rst_ready", {ifc2.if_ready, ifc2.d_ready}, 2'b00);
        chk("rst_mem_addr", ifc2.mem_addr, 32'h0);
        chk("rst_if_rdata", ifc2.if_rdata, 32'h0);

        // MEM_LAT=1: back-to-back fetches to 0x0 and 0x4, ready in cycles 3 and 7
        ifc1.if_req = 1'b1; ifc1.if_addr = 32'h0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk("l1_en", ifc1.mem_en, (c == 1 || c == 5));
            chk("l1_ready", ifc1.if_ready, (c == 3 || c == 7));
            if (c == 3) begin
                chk("l1_rdata0", ifc1.if_rdata, memword(32'h0));
                ifc1.if_addr = 32'h4;
            end
            if (c == 7) begin
                chk("l1_rdata4", ifc1.if_rdata, memword(32'h4));
                ifc1.if_req = 1'b0;
            end
        end

        // MEM_LAT=2: single fetch from 0x10
        ifc2.if_req = 1'b1; ifc2.if_addr = 32'h10;
        tick(); // cycle 1
        chk("f_en", ifc2.mem_en, 1'b1);
        chk("f_addr", ifc2.mem_addr, 32'h10);
        chk("f_we", ifc2.mem_we, 1'b0);
        chk("f_wstrb", ifc2.mem_wstrb, 4'h0);
        chk("f_gnt", ifc2.gnt_d, 1'b0);
        chk("f_busy1", ifc2.busy, 1'b1);
        tick(); // cycle 2
        chk("f_en2", ifc2.mem_en, 1'b0);
        chk("f_addr2", ifc2.mem_addr, 32'h0);
        chk("f_busy2", ifc2.busy, 1'b1);
        tick(); // cycle 3
        chk("f_ready3", ifc2.if_ready, 1'b0);
        chk("f_busy3", ifc2.busy, 1'b1);
        tick(); // cycle 4
        chk("f_ready4", ifc2.if_ready, 1'b1);
        chk("f_rdata", ifc2.if_rdata, 32'hDEAD_BEEF);
        chk("f_dready4", ifc2.d_ready, 1'b0);
        chk("f_busy4", ifc2.busy, 1'b1);
        ifc2.if_req = 1'b0;
        tick(); // cycle 5
        chk("f_ready5", ifc2.if_ready, 1'b0);
        chk("f_busy5", ifc2.busy, 1'b0);

        // store to 0x20
        ifc2.d_req = 1'b1; ifc2.d_we = 1'b1; ifc2.d_addr = 32'h20;
        ifc2.d_wdata = 32'h1234_5678; ifc2.d_wstrb = 4'hF;
        tick(); // cycle 1
        chk("s_en", ifc2.mem_en, 1'b1);
        chk("s_we", ifc2.mem_we, 1'b1);
        chk("s_addr", ifc2.mem_addr, 32'h20);
        chk("s_wdata", ifc2.mem_wdata, 32'h1234_5678);
        chk("s_wstrb", ifc2.mem_wstrb, 4'hF);
        chk("s_gnt", ifc2.gnt_d, 1'b1);
        tick(); // cycle 2
        chk("s_we2", ifc2.mem_we, 1'b0);
        chk("s_wdata2", ifc2.mem_wdata, 32'h0);
        tick(); tick(); // cycle 4
        chk("s_ready", ifc2.d_ready, 1'b1);
        chk("s_rdata", ifc2.d_rdata, 32'h0);
        chk("s_ifready", ifc2.if_ready, 1'b0);
        ifc2.d_req = 1'b0; ifc2.d_we = 1'b0; ifc2.d_wstrb = 4'h0;
        tick();

        // both requesting continuously after reset: data, fetch, data, fetch
        reset = 1'b1; tick(); reset = 1'b0;
        ifc2.if_req = 1'b1; ifc2.if_addr = 32'h40;
        ifc2.d_req = 1'b1; ifc2.d_we = 1'b0; ifc2.d_addr = 32'h80;
        for (int c = 1; c <= 20; c++) begin
            tick();
            chk("rr_en", ifc2.mem_en, (c % 5 == 1));
            if (c % 5 == 1) chk("rr_gnt", ifc2.gnt_d, (c == 1 || c == 11));
            chk("rr_dready", ifc2.d_ready, (c == 4 || c == 14));
            chk("rr_ifready", ifc2.if_ready, (c == 9 || c == 19));
            if (c == 4) chk("rr_drdata", ifc2.d_rdata, memword(32'h80));
            if (c == 9) chk("rr_ifrdata", ifc2.if_rdata, memword(32'h40));
        end
        ifc2.if_req = 1'b0; ifc2.d_req = 1'b0;
        tick();
        chk("rr_idle", ifc2.busy, 1'b0);

        // reset asserted during WAIT of a load
        ifc2.d_req = 1'b1; ifc2.d_we = 1'b0; ifc2.d_addr = 32'h30;
        tick(); tick(); // cycle 2, WAIT
        chk("ab_busy_pre", ifc2.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("ab_en", ifc2.mem_en, 1'b0);
        chk("ab_busy", ifc2.busy, 1'b0);
        chk("ab_gnt", ifc2.gnt_d, 1'b0);
        chk("ab_drdata", ifc2.d_rdata, 32'h0);
        ifc2.d_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        ifc2.if_req = 1'b1; ifc2.if_addr = 32'h14;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("ab_dready", ifc2.d_ready, 1'b0);
            chk("ab_en_post", ifc2.mem_en, (c == 1));
            chk("ab_ifready", ifc2.if_ready, (c == 4));
            if (c == 4) begin
                chk("ab_ifrdata", ifc2.if_rdata, memword(32'h14));
                ifc2.if_req = 1'b0;
            end
        end

        // fetch drops req early; d_req rises during the fetch WAIT
        ifc2.if_req = 1'b1; ifc2.if_addr = 32'h8;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) begin
                ifc2.if_req = 1'b0;
                ifc2.d_req = 1'b1; ifc2.d_we = 1'b0; ifc2.d_addr = 32'h50;
            end
            chk("pd_en", ifc2.mem_en, (c == 1 || c == 6));
            chk("pd_ifready", ifc2.if_ready, (c == 4));
            chk("pd_dready", ifc2.d_ready, (c == 9));
            if (c == 4) chk("pd_ifrdata", ifc2.if_rdata, memword(32'h8));
            if (c == 6) begin
                chk("pd_gnt", ifc2.gnt_d, 1'b1);
                chk("pd_addr", ifc2.mem_addr, 32'h50);
            end
            if (c == 9) begin
                chk("pd_drdata", ifc2.d_rdata, memword(32'h50));
                ifc2.d_req = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
